jt6295_cmd: RTL and testbench



---
 rtl/jt6295_pkg.sv | 15 +
 rtl/jt6295_cmd_hdr.sv | 54 +++++
 rtl/jt6295_cmd.sv | 135 +++++++++++++
 tb/tb_jt6295_cmd.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/jt6295_pkg.sv
// jt6295_pkg: FSM encoding and header geometry shared by the JT6295 command front end
package jt6295_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ATT,
        ST_FETCH,
        ST_ISSUE
    } state_t;

    localparam int HDR_BYTES = 6;
    localparam int HDR_SHIFT = 3;
    localparam int ADDR_W    = 18;

endpackage

// File: rtl/jt6295_cmd_hdr.sv
// jt6295_cmd_hdr: fetches the 6-byte phrase header from ROM and assembles start/stop addresses
module jt6295_cmd_hdr
    import jt6295_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              go_i,
    input  logic [6:0]        phrase_i,
    input  logic [7:0]        rom_data_i,
    input  logic              rom_ok_i,
    output logic              rom_cs_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] hdr_start_o,
    output logic [ADDR_W-1:0] hdr_stop_o
);

    localparam int SH_W = (HDR_BYTES - 1) * 8;

    logic            act_q, act_d;
    logic [2:0]      k_q, k_d;
    logic [SH_W-1:0] sh_q, sh_d;
    logic            take;
    logic            unused_b0_hi;

    assign take         = act_q & rom_ok_i;
    assign done_o       = take & (k_q == 3'(HDR_BYTES - 1));
    assign rom_cs_o     = act_q;
    assign rom_addr_o   = ADDR_W'({phrase_i, HDR_SHIFT'(0)}) + ADDR_W'(k_q);
    assign hdr_start_o  = {sh_q[33:32], sh_q[31:16]};
    assign hdr_stop_o   = {sh_q[9:8], sh_q[7:0], rom_data_i};
    assign unused_b0_hi = ^sh_q[SH_W-1:34];

    // Restart on go, then shift in one byte per accepted ROM beat until the last one
    always_comb begin
        act_d = go_i | (act_q & ~done_o);
        k_d   = go_i ? 3'd0 : take ? k_q + 3'd1 : k_q;
        sh_d  = take ? {sh_q[SH_W-9:0], rom_data_i} : sh_q;
    end

    // Fetch state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q <= 1'b0;
            k_q   <= 3'd0;
            sh_q  <= '0;
        end else begin
            act_q <= act_d;
            k_q   <= k_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/jt6295_cmd.sv
// jt6295_cmd: MSM6295 CPU command decoder and start/stop driver; JT6295_HDR_CHECK_EN discards bad headers
module jt6295_cmd
    import jt6295_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cen_i,
    input  logic              wrn_i,
    input  logic [7:0]        din_i,
    output logic [7:0]        dout_o,
    input  logic [3:0]        busy_i,
    output logic              rom_cs_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [7:0]        rom_data_i,
    input  logic              rom_ok_i,
    output logic [ADDR_W-1:0] start_addr_o,
    output logic [ADDR_W-1:0] stop_addr_o,
    output logic [3:0]        att_o,
    output logic [3:0]        start_o,
    output logic [3:0]        stop_o
);

    state_t            state_q, state_d;
    logic [6:0]        phrase_q, phrase_d;
    logic [3:0]        chmask_q, chmask_d;
    logic [3:0]        att_l_q, att_l_d;
    logic [3:0]        att_q, att_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [ADDR_W-1:0] stop_addr_q, stop_addr_d;
    logic [3:0]        start_q, start_d;
    logic [3:0]        stop_q, stop_d;
    logic              go, done, hdr_bad, wr, stop_wr;
    logic [ADDR_W-1:0] hdr_start, hdr_stop;

    assign wr           = ~wrn_i;
    assign stop_wr      = wr & ~din_i[7] & (state_q != ST_WAIT_ATT);
    assign dout_o       = {4'h0, busy_i};
    assign att_o        = att_q;
    assign start_addr_o = start_addr_q;
    assign stop_addr_o  = stop_addr_q;
    assign start_o      = start_q;
    assign stop_o       = stop_q;

`ifdef JT6295_HDR_CHECK_EN
    assign hdr_bad = (hdr_start >= hdr_stop) || (hdr_start == '0);
`else
    assign hdr_bad = 1'b0;
`endif

    jt6295_cmd_hdr u_hdr (
        .clk         (clk),
        .rst         (rst),
        .go_i        (go),
        .phrase_i    (phrase_q),
        .rom_data_i  (rom_data_i),
        .rom_ok_i    (rom_ok_i),
        .rom_cs_o    (rom_cs_o),
        .rom_addr_o  (rom_addr_o),
        .done_o      (done),
        .hdr_start_o (hdr_start),
        .hdr_stop_o  (hdr_stop)
    );

    // Command FSM; a stop written on a cen cycle survives into the next cen window
    always_comb begin
        state_d      = state_q;
        phrase_d     = phrase_q;
        chmask_d     = chmask_q;
        att_l_d      = att_l_q;
        att_d        = att_q;
        start_addr_d = start_addr_q;
        stop_addr_d  = stop_addr_q;
        start_d      = start_q;
        go           = 1'b0;
        stop_d       = (cen_i ? 4'd0 : stop_q) | (stop_wr ? din_i[6:3] : 4'd0);
        case (state_q)
            ST_IDLE: begin
                if (wr && din_i[7]) begin
                    phrase_d = din_i[6:0];
                    state_d  = ST_WAIT_ATT;
                end
            end
            ST_WAIT_ATT: begin
                if (wr) begin
                    chmask_d = din_i[7:4];
                    att_l_d  = din_i[3:0];
                    go       = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (done) begin
                    start_addr_d = hdr_start;
                    stop_addr_d  = hdr_stop;
                    att_d        = att_l_q;
                    start_d      = hdr_bad ? 4'd0 : chmask_q & ~busy_i;
                    state_d      = hdr_bad ? ST_IDLE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cen_i) begin
                    start_d = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phrase_q     <= '0;
            chmask_q     <= '0;
            att_l_q      <= '0;
            att_q        <= '0;
            start_addr_q <= '0;
            stop_addr_q  <= '0;
            start_q      <= '0;
            stop_q       <= '0;
        end else begin
            state_q      <= state_d;
            phrase_q     <= phrase_d;
            chmask_q     <= chmask_d;
            att_l_q      <= att_l_d;
            att_q        <= att_d;
            start_addr_q <= start_addr_d;
            stop_addr_q  <= stop_addr_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
        end
    end

endmodule

// File: tb/tb_jt6295_cmd.sv
// tb_jt6295_cmd: directed checks of the JT6295 command front end
module tb_jt6295_cmd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        wrn = 1'b1;
    logic        rom_ok = 1'b1;
    logic [7:0]  din = 8'h00;
    logic [3:0]  busy = 4'h0;
    logic [7:0]  dout, rom_data;
    logic [3:0]  att, start, stop;
    logic        rom_cs;
    logic [17:0] rom_addr, start_addr, stop_addr;
    logic [7:0]  rom [0:1023];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr[9:0]];

    jt6295_cmd dut (
        .clk          (clk),
        .rst          (rst),
        .cen_i        (cen),
        .wrn_i        (wrn),
        .din_i        (din),
        .dout_o       (dout),
        .busy_i       (busy),
        .rom_cs_o     (rom_cs),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .rom_ok_i     (rom_ok),
        .start_addr_o (start_addr),
        .stop_addr_o  (stop_addr),
        .att_o        (att),
        .start_o      (start),
        .stop_o       (stop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] b);
        wrn = 1'b0;
        din = b;
        step(1);
        wrn = 1'b1;
    endtask

    task automatic tick_cen();
        cen = 1'b1;
        step(1);
        cen = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'(i * 7 + 3);
        rom[40] = 8'h01; rom[41] = 8'h23; rom[42] = 8'h45;
        rom[43] = 8'h02; rom[44] = 8'h00; rom[45] = 8'h10;
        rom[48] = 8'h00; rom[49] = 8'h01; rom[50] = 8'h00;
        rom[51] = 8'h00; rom[52] = 8'h01; rom[53] = 8'h00;
        busy = 4'b0101;
        step(3);
        check("rst_start", start, 0);
        check("rst_stop", stop, 0);
        check("rst_rom_cs", rom_cs, 0);
        check("rst_att", att, 0);
        check("rst_start_addr", start_addr, 0);
        check("rst_stop_addr", stop_addr, 0);
        check("rst_dout", dout, 8'h05);
        rst = 1'b0;
        busy = 4'b0000;
        check("dout_zero", dout, 8'h00);

        // Basic phrase start
        wr(8'h85);
        wr(8'h13);
        check("att_before_done", att, 0);
        for (int i = 0; i < 6; i++) begin
            check("fetch_addr", rom_addr, 32'h28 + i);
            check("fetch_cs", rom_cs, 1);
            step(1);
        end
        check("issue_start", start, 4'b0001);
        check("issue_start_addr", start_addr, 18'h12345);
        check("issue_stop_addr", stop_addr, 18'h20010);
        check("issue_att", att, 3);
        check("issue_cs_off", rom_cs, 0);
        step(2);
        check("start_held", start, 4'b0001);
        cen = 1'b1;
        check("start_at_cen", start, 4'b0001);
        step(1);
        cen = 1'b0;
        check("start_cleared", start, 0);

        // Stop commands
        wr(8'h48);
        check("stop_set", stop, 4'b1001);
        step(1);
        check("stop_held", stop, 4'b1001);
        wrn = 1'b0; din = 8'h08; cen = 1'b1;
        step(1);
        wrn = 1'b1; cen = 1'b0;
        check("stop_on_cen_kept", stop, 4'b0001);
        tick_cen();
        check("stop_cleared", stop, 0);

        // Busy channels masked from start
        busy = 4'b0100;
        check("dout_busy", dout, 8'h04);
        wr(8'h85);
        wr(8'hF0);
        step(6);
        check("busy_mask_start", start, 4'b1011);
        check("busy_att", att, 0);
        busy = 4'b0000;
        step(1);
        check("busy_sampled_once", start, 4'b1011);
        tick_cen();
        check("busy_start_cleared", start, 0);

        // Writes during fetch: phrase byte dropped, stop accepted
        wr(8'h85);
        wr(8'h13);
        wr(8'h81);
        wr(8'h20);
        check("fetch_stop", stop, 4'b0100);
        check("fetch_addr_kept", rom_addr, 18'h2A);
        step(4);
        check("fetch_wr_start", start, 4'b0001);
        check("fetch_wr_start_addr", start_addr, 18'h12345);
        tick_cen();
        check("fetch_wr_start_clr", start, 0);
        check("fetch_wr_stop_clr", stop, 0);

        // Reset in the middle of a fetch
        wr(8'h85);
        wr(8'h13);
        step(3);
        check("pre_rst_addr", rom_addr, 18'h2B);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_cs", rom_cs, 0);
        check("mid_rst_start", start, 0);
        check("mid_rst_start_addr", start_addr, 0);
        step(6);
        check("mid_rst_no_start", start, 0);
        check("mid_rst_cs_off", rom_cs, 0);
        wr(8'h13);
        check("mid_rst_idle", stop, 4'b0010);
        tick_cen();

        // ROM stall on byte 2
        wr(8'h85);
        wr(8'h13);
        step(2);
        check("stall_addr_a", rom_addr, 18'h2A);
        rom_ok = 1'b0;
        step(3);
        check("stall_addr_b", rom_addr, 18'h2A);
        check("stall_cs", rom_cs, 1);
        check("stall_no_start", start, 0);
        rom_ok = 1'b1;
        step(4);
        check("stall_start", start, 4'b0001);
        check("stall_start_addr", start_addr, 18'h12345);
        check("stall_stop_addr", stop_addr, 18'h20010);
        tick_cen();

        // Degenerate header start == stop
        wr(8'h86);
        wr(8'h11);
        step(6);
`ifdef JT6295_HDR_CHECK_EN
        check("hdr_bad_no_start", start, 0);
        step(2);
        check("hdr_bad_still_no_start", start, 0);
        wr(8'h13);
        check("hdr_bad_idle", stop, 4'b0010);
`else
        check("hdr_raw_start", start, 4'b0001);
        check("hdr_raw_start_addr", start_addr, 18'h00100);
        check("hdr_raw_stop_addr", stop_addr, 18'h00100);
        tick_cen();
        check("hdr_raw_start_clr", start, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
